// File: rtl/mux_arbiter_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
// Holds the FSM state encoding, requester count and select type.
package mux_arbiter_pkg;

  localparam int N_REQ = 4;

  typedef logic [1:0] sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/mux_arbiter_rr_pick.sv
// Combinational round-robin search: first set request bit at or after
// (last+1) mod 4, wrapping around; any flags that some request is set.
module rr_pick
  import mux_arbiter_pkg::*;
(
  input  logic [3:0] req,
  input  sel_t       last,
  output logic       any,
  output sel_t       idx
);

  sel_t cand;
  logic found;

  always_comb begin
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    // Offset 4 wraps to last itself, so the previous winner is searched last.
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter that registers the granted requester's word and
// holds it until downstream accepts, then pulses a one-hot ack.
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output sel_t              cs,
  output logic [N_REQ-1:0]  ack
);

  state_t            state;
  sel_t              last_grant;
  sel_t              win;
  logic              any;
  logic [DATA_W-1:0] win_word;

  function automatic logic [N_REQ-1:0] onehot(input sel_t s);
    onehot    = '0;
    onehot[s] = 1'b1;
  endfunction

  rr_pick u_rr_pick (
    .req  (req),
    .last (last_grant),
    .any  (any),
    .idx  (win)
  );

  always_comb begin
    win_word = '0;
    case (win)
      2'd0:    win_word = a;
      2'd1:    win_word = b;
      2'd2:    win_word = c;
      default: win_word = d;
    endcase
  end

  // last_grant resets to 3 so requester 0 has first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_data   <= '0;
      cs         <= '0;
      ack        <= '0;
      last_grant <= 2'd3;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (any) begin
            cs        <= win;
            out_data  <= win_word;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          // Held word survives request withdrawal and data changes.
          if (out_ready) begin
            ack        <= onehot(cs);
            last_grant <= cs;
            out_valid  <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
